// File: rtl/if_id_queue.sv
// ============================================================================
// if_id_queue
//
// Purpose:
//   A DEPTH-entry first-word-fall-through queue that sits between instruction
//   fetch and decode. It replaces the single-entry IF/ID pipeline register.
//   Each entry holds {instruction, PC+4}. Valid/ready handshakes on both sides
//   take the place of the old write-enable stall. The queue keeps the branch
//   flush, the debug clock-enable (db_ena) and the end-of-program (PC_end)
//   gating of its predecessor, and adds occupancy and drain status.
//
// Parameters:
//   INST_W  instruction width
//   PC_W    PC+4 width
//   DEPTH   number of entries (power of two, >= 2)
//   CNT_W   occupancy counter width (derived from DEPTH)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (overrides db_ena)
//   db_ena      debug clock enable; 0 freezes pointers, count and storage
//   flush       discards every entry at the next edge (only when db_ena=1)
//   PC_end      end of execution; blocks pushes, pops still drain
//   in_valid    fetch presents an entry
//   in_ready    queue accepts an entry this cycle
//   in_inst     fetched instruction
//   in_PCnext   PC+4 of the fetched instruction
//   out_valid   head entry is valid
//   out_ready   decode accepts the head (the hazard unit drives 0 to stall)
//   out_inst    head instruction; 0 (NOP) when empty
//   out_PCnext  head PC+4; 0 when empty
//   count       occupancy, 0..DEPTH
//   full        count == DEPTH
//   empty       count == 0
//   drained     PC_end && empty
// ============================================================================
module if_id_queue #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              db_ena,
    input  logic              flush,
    input  logic              PC_end,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_PCnext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_PCnext,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              drained
);

    localparam int PTR_W = $clog2(DEPTH);

    // Elaboration-time guard on the geometry. Natural pointer wrap only works
    // for a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("if_id_queue: DEPTH must be a power of two and >= 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;

    logic              push;
    logic              pop;

    // ------------------------------------------------------------------
    // Status and handshake
    // ------------------------------------------------------------------
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign drained   = PC_end && empty;
    assign out_valid = !empty;

    // in_ready is deliberately independent of out_ready. A full queue refuses
    // a push even when the head pops in the same cycle. This keeps the fetch
    // side free of a combinational path through the decode/hazard logic.
    assign in_ready = db_ena && !flush && !PC_end && !full;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready && db_ena && !flush;

    // First-word fall-through. The head is read combinationally. An empty
    // queue presents a NOP (all zeros) so decode sees a bubble, not stale data.
    always_comb begin
        out_inst   = '0;
        out_PCnext = '0;
        if (!empty) begin
            out_inst   = inst_mem[rd_ptr];
            out_PCnext = pc_mem[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Storage write (data only, never reset)
    // ------------------------------------------------------------------
    // push already implies db_ena && !flush. Gating with !reset means that a
    // handshake coinciding with reset leaves no trace, not even in storage.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_PCnext;
        end
    end

    // ------------------------------------------------------------------
    // Pointer and occupancy control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (db_ena) begin
            if (flush) begin
                // Discard everything by catching the read pointer up to the
                // write pointer. Any same-cycle push or pop is already masked
                // off through in_ready and pop.
                rd_ptr <= wr_ptr;
                cnt_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Invariants: the handshake gating makes overflow and underflow
    // unreachable. These checks flag any regression of that gating.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full))
                else $error("if_id_queue: push while full");
            assert (!(pop && empty))
                else $error("if_id_queue: pop while empty");
            assert (cnt_q <= CNT_W'(DEPTH))
                else $error("if_id_queue: occupancy above DEPTH");
            assert (full || (PTR_W'(wr_ptr - rd_ptr) == PTR_W'(cnt_q)))
                else $error("if_id_queue: pointers disagree with count");
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// ============================================================================
// tb_if_id_queue
//
// Directed testbench for if_id_queue with DEPTH=4. Inputs change 1 ns after
// each rising edge. Outputs are sampled 1 ns later, well away from the edge.
// ============================================================================
module tb_if_id_queue;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              db_ena;
    logic              flush;
    logic              PC_end;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_PCnext;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_PCnext;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              drained;

    int checks = 0;
    int errors = 0;

    if_id_queue #(
        .INST_W(INST_W),
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .db_ena    (db_ena),
        .flush     (flush),
        .PC_end    (PC_end),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_PCnext (in_PCnext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_PCnext(out_PCnext),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drained   (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n entries back to back, with inst = base+i and PC+4 = pcb+4*i.
    task automatic load(input int n, input logic [31:0] base, input logic [31:0] pcb);
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_inst   = base + 32'(i);
            in_PCnext = pcb + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", count);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got empty=%b full=%b out_valid=%b exp 1/0/0", empty, full, out_valid);
        end
        checks++;
        if (out_inst !== 32'h0 || out_PCnext !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h exp 0/0", out_inst, out_PCnext);
        end
        checks++;
        if (drained !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got drained=%b in_ready=%b exp 0/1", drained, in_ready);
        end
        tick();
    endtask

    task automatic test_fifo_order();
        logic [31:0] exp_inst [3];
        logic [31:0] exp_pc   [3];
        exp_inst[0] = 32'h11111111; exp_pc[0] = 32'h4;
        exp_inst[1] = 32'h22222222; exp_pc[1] = 32'h8;
        exp_inst[2] = 32'h33333333; exp_pc[2] = 32'hC;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_inst   = exp_inst[i];
            in_PCnext = exp_pc[i];
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL order_count got %0d exp 3", count);
        end
        checks++;
        if (out_inst !== 32'h11111111 || out_PCnext !== 32'h4) begin
            errors++;
            $display("FAIL order_head got %h/%h exp 11111111/4", out_inst, out_PCnext);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_inst !== exp_inst[i] || out_PCnext !== exp_pc[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL order_pop%0d got %h/%h v=%b exp %h/%h v=1",
                         i, out_inst, out_PCnext, out_valid, exp_inst[i], exp_pc[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || out_inst !== 32'h0 || out_PCnext !== 32'h0) begin
            errors++;
            $display("FAIL order_empty got empty=%b %h/%h exp 1 0/0", empty, out_inst, out_PCnext);
        end
        tick();
    endtask

    task automatic test_full_wrap();
        logic [31:0] q_inst [$];
        logic [31:0] q_pc   [$];
        logic [31:0] nxt;
        logic        exp_rdy;
        int          sz;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_inst.push_back(32'hA0000000 + 32'(i));
            q_pc.push_back(32'h100 + 32'(4 * i));
        end
        load(4, 32'hA0000000, 32'h100);
        #1;
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL full_flags got full=%b in_ready=%b count=%0d exp 1/0/4", full, in_ready, count);
        end
        // A 5th offer is refused.
        in_valid  = 1'b1;
        in_inst   = 32'hBAD0BAD0;
        in_PCnext = 32'hFFC;
        tick();
        #1;
        checks++;
        if (count !== 3'd4 || out_inst !== 32'hA0000000) begin
            errors++;
            $display("FAIL full_refuse got count=%0d head=%h exp 4 a0000000", count, out_inst);
        end
        // Streaming: in_valid and out_ready held high for 10 cycles.
        nxt = 32'hB0000000;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_inst   = nxt;
            in_PCnext = 32'h200 + ((nxt - 32'hB0000000) << 2);
            #1;
            sz = q_inst.size();
            exp_rdy = (sz != DEPTH);
            checks++;
            if (out_inst !== q_inst[0] || out_PCnext !== q_pc[0] || in_ready !== exp_rdy
                || count !== CNT_W'(sz)) begin
                errors++;
                $display("FAIL wrap_c%0d got %h/%h rdy=%b cnt=%0d exp %h/%h rdy=%b cnt=%0d",
                         c, out_inst, out_PCnext, in_ready, count, q_inst[0], q_pc[0], exp_rdy, sz);
            end
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
            if (exp_rdy) begin
                q_inst.push_back(in_inst);
                q_pc.push_back(in_PCnext);
                nxt = nxt + 32'd1;
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (count < 3'd3 || count > 3'd4) begin
            errors++;
            $display("FAIL wrap_range got %0d exp 3..4", count);
        end
        // Drain and confirm the order survived the wrap.
        while (q_inst.size() > 0) begin
            #1;
            checks++;
            if (out_inst !== q_inst[0] || out_PCnext !== q_pc[0]) begin
                errors++;
                $display("FAIL wrap_drain got %h/%h exp %h/%h", out_inst, out_PCnext, q_inst[0], q_pc[0]);
            end
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_empty got %b exp 1", empty);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        load(3, 32'hC0000000, 32'h300);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hDEADBEEF;
        in_PCnext = 32'hEEC;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b exp 0", in_ready);
        end
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_inst !== 32'h0 || out_PCnext !== 32'h0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear got cnt=%0d %h/%h empty=%b exp 0 0/0 1", count, out_inst, out_PCnext, empty);
        end
        load(1, 32'hE0000000, 32'h400);
        #1;
        checks++;
        if (count !== 3'd1 || out_inst !== 32'hE0000000 || out_PCnext !== 32'h400) begin
            errors++;
            $display("FAIL flush_resume got cnt=%0d %h/%h exp 1 e0000000/400", count, out_inst, out_PCnext);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_db_ena();
        out_ready = 1'b0;
        load(2, 32'hD0000000, 32'h500);
        db_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0];
            out_ready = !i[0];
            flush     = (i == 2);
            in_inst   = 32'h5A5A0000 + 32'(i);
            #1;
            checks++;
            if (in_ready !== 1'b0 || count !== 3'd2 || out_inst !== 32'hD0000000
                || out_PCnext !== 32'h500) begin
                errors++;
                $display("FAIL dbena_hold%0d got rdy=%b cnt=%0d %h/%h exp 0 2 d0000000/500",
                         i, in_ready, count, out_inst, out_PCnext);
            end
            tick();
        end
        db_ena    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (out_inst !== 32'hD0000000 + 32'(i) || out_PCnext !== 32'h500 + 32'(4 * i)) begin
                errors++;
                $display("FAIL dbena_resume%0d got %h/%h exp %h/%h",
                         i, out_inst, out_PCnext, 32'hD0000000 + 32'(i), 32'h500 + 32'(4 * i));
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL dbena_empty got %b exp 1", empty);
        end
        tick();
    endtask

    task automatic test_pc_end();
        out_ready = 1'b0;
        load(3, 32'hF0000000, 32'h600);
        PC_end    = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h0BADF00D;
        #1;
        checks++;
        if (in_ready !== 1'b0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL pcend_block got rdy=%b drained=%b exp 0/0", in_ready, drained);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_inst !== 32'hF0000000 + 32'(i) || drained !== 1'b0 || count !== CNT_W'(3 - i)) begin
                errors++;
                $display("FAIL pcend_pop%0d got %h drained=%b cnt=%0d exp %h 0 %0d",
                         i, out_inst, drained, count, 32'hF0000000 + 32'(i), 3 - i);
            end
            tick();
        end
        #1;
        checks++;
        if (drained !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL pcend_drained got drained=%b empty=%b exp 1/1", drained, empty);
        end
        PC_end    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        load(2, 32'h70000000, 32'h700);
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h77777777;
        in_PCnext = 32'h770;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || out_inst !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_clear got cnt=%0d empty=%b inst=%h exp 0 1 0", count, empty, out_inst);
        end
        load(1, 32'h88888888, 32'h880);
        #1;
        checks++;
        if (count !== 3'd1 || out_inst !== 32'h88888888 || out_PCnext !== 32'h880) begin
            errors++;
            $display("FAIL rstmid_push got cnt=%0d %h/%h exp 1 88888888/880", count, out_inst, out_PCnext);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        db_ena    = 1'b1;
        flush     = 1'b0;
        PC_end    = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_PCnext = '0;
        out_ready = 1'b0;
        test_reset();
        test_fifo_order();
        test_full_wrap();
        test_flush();
        test_db_ena();
        test_pc_end();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
